// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with valid/ready, skid buffer, flush and stall counter
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous kill of every held beat
//   in_valid/in_ready   upstream handshake, in_data/in_ctrl upstream payload
//   out_valid/out_ready downstream handshake, out_data/out_ctrl held payload
//   cnt_clr             synchronous clear of stall_cnt
//   stall_cnt           saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
    parameter int                 DATA_W   = 108,
    parameter int                 CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  CTRL_RST = 8'b0011_1000,
    parameter bit                 SKID     = 1'b1,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, in_ready_q;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire, out_fire;

    // With SKID=1 in_ready comes straight from a flop, so out_ready never
    // reaches in_ready combinationally. With SKID=0 the single entry can be
    // replaced in the same cycle it drains, which needs the comb path.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = in_ready_q;
        end else begin : g_ready_comb
            assign in_ready = !out_valid_q || out_ready;
        end
    endgenerate

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    // The same FSM serves both configurations: with SKID=0 in_ready is low
    // whenever a beat is held and not leaving, so FULL is never entered.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // An empty stage always presents the bubble control so downstream
        // never sees stale control; data is left as a don't-care.
        if (state_d == ST_EMPTY) begin
            main_ctrl_d = CTRL_RST;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid (skid and single-entry instances)
module tb_pipe_stage_skid;

    localparam int         DW   = 16;
    localparam int         CW   = 8;
    localparam logic [7:0] CRST = 8'b0011_1000;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [2:0]    a_stall_cnt;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [15:0]   b_stall_cnt;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1'b1), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1'b0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt)
    );

    beat_t qa[$];
    beat_t qb[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    pops_a   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor A: pop on every out_fire, check bubble ctrl and hold stability.
    logic  a_hold_prev = 1'b0;
    beat_t a_held;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            a_hold_prev = 1'b0;
        end else begin
            if (a_hold_prev && a_out_valid) begin
                chk("a_hold_data", 32'(a_out_data), 32'(a_held.d));
                chk("a_hold_ctrl", 32'(a_out_ctrl), 32'(a_held.c));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_beat", 32'(a_out_data), 32'hFFFF_FFFF);
                end else begin
                    e = qa.pop_front();
                    chk("a_data", 32'(a_out_data), 32'(e.d));
                    chk("a_ctrl", 32'(a_out_ctrl), 32'(e.c));
                    pops_a++;
                end
            end else if (!a_out_valid) begin
                chk("a_bubble_ctrl", 32'(a_out_ctrl), 32'(CRST));
            end
            a_hold_prev = a_out_valid && !a_out_ready && !a_flush;
            a_held      = '{d: a_out_data, c: a_out_ctrl};
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_beat", 32'(b_out_data), 32'hFFFF_FFFF);
                end else begin
                    e = qb.pop_front();
                    chk("b_data", 32'(b_out_data), 32'(e.d));
                    chk("b_ctrl", 32'(b_out_ctrl), 32'(e.c));
                end
            end else if (!b_out_valid) begin
                chk("b_bubble_ctrl", 32'(b_out_ctrl), 32'(CRST));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int t;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_ctrl  = c;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (a_in_ready) break;
        end
        if (t == 50) chk("a_send_timeout", 32'd0, 32'd1);
        else qa.push_back('{d: d, c: c});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int t;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_ctrl  = c;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (b_in_ready) break;
        end
        if (t == 50) chk("b_send_timeout", 32'd0, 32'd1);
        else qb.push_back('{d: d, c: c});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    p;
        time   t0;
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1; a_cnt_clr = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1; b_cnt_clr = 0;
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_out_ctrl",  32'(a_out_ctrl),  32'(CRST));
        chk("rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        cycles(1);

        // Back-to-back beats, out_ready held high: one beat out per cycle.
        p = pops_a;
        for (int i = 0; i < 4; i++) send_a(16'h1000 + 16'(i), 8'h01 + 8'(i));
        chk("t2_no_gaps", 32'(pops_a - p), 32'd3);
        chk("t2_d3_valid", 32'(a_out_valid), 32'd1);
        chk("t2_d3_data",  32'(a_out_data),  32'h1003);
        cycles(2);
        chk("t2_drained", 32'(qa.size()), 32'd0);

        // Stall: A then B fill main+skid, C must wait upstream.
        a_out_ready = 1'b0;
        send_a(16'hA0A0, 8'h11);
        send_a(16'hB0B0, 8'h12);
        a_in_valid = 1'b1; a_in_data = 16'hC0C0; a_in_ctrl = 8'h13;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready_full", 32'(a_in_ready), 32'd0);
            chk("t3_hold_a", 32'(a_out_data), 32'hA0A0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        send_a(16'hC0C0, 8'h13);
        cycles(4);
        chk("t3_drained", 32'(qa.size()), 32'd0);

        // Stall counter saturation at 7 with CNT_W=3, then clear.
        a_cnt_clr = 1'b1; cycles(1); a_cnt_clr = 1'b0;
        a_out_ready = 1'b0;
        send_a(16'h5555, 8'h21);
        cycles(3);
        chk("t5_cnt_3", 32'(a_stall_cnt), 32'd3);
        cycles(7);
        chk("t5_cnt_sat", 32'(a_stall_cnt), 32'd7);
        a_cnt_clr = 1'b1; cycles(1); a_cnt_clr = 1'b0;
        chk("t5_cnt_clr", 32'(a_stall_cnt), 32'd0);
        a_out_ready = 1'b1;
        cycles(2);

        // Flush from FULL with X offered, then from ONE with X2 actually firing.
        a_out_ready = 1'b0;
        send_a(16'h0F01, 8'h31);
        send_a(16'h0F02, 8'h32);
        a_in_valid = 1'b1; a_in_data = 16'hDEAD; a_in_ctrl = 8'h3F;
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("t4_valid", 32'(a_out_valid), 32'd0);
        chk("t4_ctrl",  32'(a_out_ctrl),  32'(CRST));
        chk("t4_ready", 32'(a_in_ready),  32'd1);
        cycles(1);
        send_a(16'h0F03, 8'h33);
        a_in_valid = 1'b1; a_in_data = 16'hBEEF; a_in_ctrl = 8'h3E;
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        qa.delete();
        chk("t4b_valid", 32'(a_out_valid), 32'd0);
        a_out_ready = 1'b1;
        cycles(4);

        // Async reset while FULL.
        a_out_ready = 1'b0;
        send_a(16'h7001, 8'h41);
        send_a(16'h7002, 8'h42);
        cycles(1);
        #3 rst = 1'b1;
        #1;
        chk("t1_valid", 32'(a_out_valid), 32'd0);
        chk("t1_ctrl",  32'(a_out_ctrl),  32'(CRST));
        chk("t1_cnt",   32'(a_stall_cnt), 32'd0);
        chk("t1_ready", 32'(a_in_ready),  32'd1);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        send_a(16'h7003, 8'h43);
        cycles(2);
        chk("t1_after_drained", 32'(qa.size()), 32'd0);

        // Single-entry stage: comb in_ready and same-cycle replace.
        b_out_ready = 1'b0;
        send_b(16'hE000, 8'h51);
        @(negedge clk);
        chk("t6_valid", 32'(b_out_valid), 32'd1);
        chk("t6_in_ready_low", 32'(b_in_ready), 32'd0);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        t0 = $time;
        send_b(16'hE001, 8'h52);
        chk("t6_one_cycle", 32'($time - t0), 32'd10);
        chk("t6_no_bubble", 32'(b_out_valid), 32'd1);
        chk("t6_replaced",  32'(b_out_data),  32'hE001);
        cycles(2);
        chk("t6_drained", 32'(qb.size()), 32'd0);

        chk("final_qa_empty", 32'(qa.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
